// File: rtl/ticket_vend_controller.sv
// ticket_vend_controller: single-ticket vending FSM (IDLE/COLLECT/DISPENSE/REFUND).
// Latches a price code, accumulates 10/20 euro coins, dispenses with change,
// or refunds on cancel. All outputs are registered.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   selValid, selPrice[1:0]      ticket selection (01=10, 10=20, 11=30 euros)
//   coinValid, coinValue[4:0]    coin strobe and value in euros (10/20 accepted)
//   cancel                       abort request, honoured in COLLECT only
//   credit[5:0]                  euros collected in the current transaction
//   busy                         state is not IDLE
//   dispense                     one-cycle ticket release
//   change[5:0], changeValid     one-cycle change/refund amount
//   coinReject                   one-cycle pulse after an unaccepted coin
//
// Optional feature: define TICKET_TIMEOUT_EN to refund automatically after
// TIMEOUT_CYCLES inactive COLLECT cycles.
module ticket_vend_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       selValid,
  input  logic [1:0] selPrice,
  input  logic       coinValid,
  input  logic [4:0] coinValue,
  input  logic       cancel,
  output logic [5:0] credit,
  output logic       busy,
  output logic       dispense,
  output logic [5:0] change,
  output logic       changeValid,
  output logic       coinReject
);

  localparam int unsigned CW = 6;

  // Timeout parameter sanity check at elaboration.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    REFUND   = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] price, price_nx;
  logic [CW-1:0] credit_nx, change_nx, sum;
  logic          busy_nx, dispense_nx, change_valid_nx, coin_reject_nx;
  logic          coin_ok;

`ifdef TICKET_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer, timer_nx;
`endif

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      price       <= '0;
      credit      <= '0;
      busy        <= 1'b0;
      dispense    <= 1'b0;
      change      <= '0;
      changeValid <= 1'b0;
      coinReject  <= 1'b0;
`ifdef TICKET_TIMEOUT_EN
      timer       <= '0;
`endif
    end else begin
      state       <= state_nx;
      price       <= price_nx;
      credit      <= credit_nx;
      busy        <= busy_nx;
      dispense    <= dispense_nx;
      change      <= change_nx;
      changeValid <= change_valid_nx;
      coinReject  <= coin_reject_nx;
`ifdef TICKET_TIMEOUT_EN
      timer       <= timer_nx;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx        = state;
    price_nx        = price;
    credit_nx       = credit;
    change_nx       = '0;
    change_valid_nx = 1'b0;
    dispense_nx     = 1'b0;
    coin_reject_nx  = 1'b0;
    coin_ok         = coinValid && (coinValue == 5'd10 || coinValue == 5'd20);
    // Max 20 held + 20 coin = 40, so 6 bits never wrap.
    sum             = credit + CW'(coinValue);
`ifdef TICKET_TIMEOUT_EN
    // Default clear covers both COLLECT entry and accepted coins.
    timer_nx        = '0;
`endif

    unique case (state)
      IDLE: begin
        coin_reject_nx = coinValid;
        if (selValid && selPrice != 2'b00) begin
          state_nx = COLLECT;
          unique case (selPrice)
            2'b01:   price_nx = CW'(10);
            2'b10:   price_nx = CW'(20);
            default: price_nx = CW'(30);
          endcase
        end
      end

      COLLECT: begin
        if (cancel) begin
          // Cancel wins over a same-cycle coin, which is bounced.
          state_nx        = REFUND;
          coin_reject_nx  = coinValid;
          change_nx       = credit;
          change_valid_nx = (credit != '0);
        end else if (coin_ok) begin
          credit_nx = sum;
          if (sum >= price) begin
            state_nx        = DISPENSE;
            change_nx       = sum - price;
            change_valid_nx = (sum != price);
            dispense_nx     = 1'b1;
          end
        end else begin
          coin_reject_nx = coinValid;
`ifdef TICKET_TIMEOUT_EN
          if (timer == TIMER_LAST) begin
            state_nx        = REFUND;
            change_nx       = credit;
            change_valid_nx = (credit != '0);
          end else begin
            timer_nx = timer + TW'(1);
          end
`endif
        end
      end

      DISPENSE, REFUND: begin
        state_nx       = IDLE;
        credit_nx      = '0;
        price_nx       = '0;
        coin_reject_nx = coinValid;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: doc/ticket_vend_controller.md
TICKET_VEND_CONTROLLER -- requirements
Module: ticket_vend_controller

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 1000, COLLECT-state inactivity limit in clock cycles (used only with TICKET_TIMEOUT_EN).
REQ-002 SHALL have port: clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: selValid  input  1  ticket selection strobe, sampled each cycle.
REQ-005 SHALL have port: selPrice  input  2  price code: 01=10, 10=20, 11=30 euros; 00 invalid.
REQ-006 SHALL have port: coinValid  input  1  coin strobe, one cycle per coin.
REQ-007 SHALL have port: coinValue  input  5  coin value in euros; only 10 and 20 accepted.
REQ-008 SHALL have port: cancel  input  1  user abort request.
REQ-009 SHALL have port: credit  output  6  accumulated euros in current transaction (0..40).
REQ-010 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port: dispense  output  1  one-cycle ticket release pulse.
REQ-012 SHALL have port: change  output  6  euros returned; valid only when changeValid=1, else 0.
REQ-013 SHALL have port: changeValid  output  1  one-cycle change/refund pulse.
REQ-014 SHALL have port: coinReject  output  1  one-cycle pulse, cycle after an unaccepted coin.

Function
REQ-015 SHALL implement states IDLE, COLLECT, DISPENSE, REFUND; all outputs registered.
REQ-016 IDLE: selValid=1 with selPrice!=00 SHALL latch price (10/20/30) and enter COLLECT next cycle; selPrice=00 ignored.
REQ-017 Coin in IDLE, DISPENSE or REFUND SHALL be rejected (coinReject=1 next cycle, credit unchanged).
REQ-018 COLLECT: accepted coin (10 or 20) sampled in cycle N SHALL make credit=credit+coinValue in cycle N+1.
REQ-019 COLLECT: coinValue not 10/20 SHALL be rejected; credit unchanged.
REQ-020 COLLECT: when updated credit >= price, SHALL enter DISPENSE in the same cycle credit updates (N+1).
REQ-021 DISPENSE: one cycle, dispense=1, change=credit-price, changeValid=1 only if change>0; next cycle credit=0, state IDLE.
REQ-022 COLLECT: cancel=1 SHALL enter REFUND next cycle; cancel has priority over a same-cycle coin, which is rejected.
REQ-023 REFUND: one cycle, change=credit, changeValid=1 only if credit>0; next cycle credit=0, state IDLE.
REQ-024 selValid outside IDLE SHALL be ignored; cancel outside COLLECT SHALL be ignored.
REQ-025 Maximum credit 40 (20 held + 20 coin at price 30); 6-bit arithmetic SHALL not wrap.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE, credit=0, price=0, dispense=0, changeValid=0, change=0, coinReject=0, busy=0, timer=0.
REQ-027 Reset mid-transaction SHALL discard credit with no refund pulse; reset dominates all inputs.

Configuration
REQ-028 Macro TICKET_TIMEOUT_EN defined: counter SHALL clear on COLLECT entry and on each accepted coin, increment each other COLLECT cycle, and on reaching TIMEOUT_CYCLES-1 enter REFUND next cycle.
REQ-029 Macro TICKET_TIMEOUT_EN undefined: no counter SHALL be built; COLLECT waits indefinitely for coins or cancel.

Verification
REQ-030 Select 30, coins 10,20 -> credit 10 then 30, dispense=1 one cycle, changeValid=0, IDLE.
REQ-031 Select 10, coin 20 -> dispense=1, change=10, changeValid=1 same cycle, credit 0 after.
REQ-032 Select 30, coin 20, then cancel + coin 10 same cycle -> coinReject=1, REFUND change=20, changeValid=1.
REQ-033 Idle coin 10, then COLLECT coin 5 -> coinReject=1 each, credit stays 0.
REQ-034 Select 20, coin 10, reset -> next cycle all outputs 0, busy=0, no changeValid.
REQ-035 TICKET_TIMEOUT_EN, TIMEOUT_CYCLES=8: select 30, coin 10, no activity -> REFUND change=10 after 8 cycles.
